// File: rtl/tdc_thermo_decoder.sv
`default_nettype none
// ============================================================================
// Module  : tdc_thermo_decoder
// Brief   : Pipelined stop-column decoder for a tapped-delay-line TDC. Takes
//           one sampled FF column per clock and returns the bin of the
//           selected level transition, together with no-edge and bubble
//           (multiple-edge) flags.
// Revision: 1.0 - initial pipelined release
// ----------------------------------------------------------------------------
// Parameters
//   NUM_FF    : taps in the sampled column
//   BITS_DECO : bin output width (2**BITS_DECO must exceed NUM_FF-GUARD)
//   WIN       : consecutive post-edge taps that must equal the new level (1..8)
//   GUARD     : top taps excluded as an edge start (must be >= WIN)
//   EDGE_POL  : 1 = find 0->1 transition, 0 = find 1->0 transition
// Ports
//   wClk         in   clock, rising edge
//   wRst         in   asynchronous active-high reset
//   wSampleValid in   wDecoIn carries a valid column this cycle
//   wDecoIn      in   sampled column, bit 0 = first tap
//   wDecoOut     out  decoded bin (i+1 of highest match), 0 if none
//   wDecoValid   out  one-cycle strobe qualifying wDecoOut and the flags
//   wDecoNoEdge  out  no match in the scan range
//   wDecoMulti   out  more than one match in the scan range (bubble)
// Optional feature (macro TDC_DECO_STATS_EN)
//   wStatClr     in   synchronous clear of both counters (wins over increment)
//   wStatNoEdge  out  saturating count of valid no-edge results
//   wStatMulti   out  saturating count of valid multi-edge results
// Pipeline: S1 input register, S2 match vector, S3 encoder/flags -> outputs.
// Latency 3 clocks, throughput 1 sample per clock, no backpressure.
// ============================================================================
module tdc_thermo_decoder #(
   parameter int NUM_FF    = 192,
   parameter int BITS_DECO = 8,
   parameter int WIN       = 4,
   parameter int GUARD     = 20,
   parameter int EDGE_POL  = 1
) (
   input  logic                 wClk,
   input  logic                 wRst,
   input  logic                 wSampleValid,
   input  logic [NUM_FF-1:0]    wDecoIn,
   output logic [BITS_DECO-1:0] wDecoOut,
   output logic                 wDecoValid,
   output logic                 wDecoNoEdge,
   output logic                 wDecoMulti
`ifdef TDC_DECO_STATS_EN
   ,
   input  logic                 wStatClr,
   output logic [15:0]          wStatNoEdge,
   output logic [15:0]          wStatMulti
`endif
);

   // Number of candidate edge positions i = 0 .. c_scan-1
   localparam int c_scan = NUM_FF - GUARD;
   // Highest tap a candidate can reference is c_scan-1+WIN; taps above are
   // never looked at, so they are not carried through the pipeline.
   localparam int c_used = ((c_scan + WIN) < NUM_FF) ? (c_scan + WIN) : NUM_FF;
   localparam logic c_pol = (EDGE_POL != 0);

   // ------------------------------------------------------------------------
   // Elaboration-time configuration checks
   // ------------------------------------------------------------------------
   if ((2 ** BITS_DECO) <= c_scan) begin : g_chk_width
      $error("tdc_thermo_decoder: BITS_DECO too small for NUM_FF-GUARD");
   end
   if (GUARD < WIN) begin : g_chk_guard
      $error("tdc_thermo_decoder: GUARD must be >= WIN");
   end
   if ((WIN < 1) || (WIN > 8)) begin : g_chk_win
      $error("tdc_thermo_decoder: WIN must be in 1..8");
   end

   if (c_used < NUM_FF) begin : g_unused_taps
      logic w_unused_taps;
      assign w_unused_taps = ^wDecoIn[NUM_FF-1:c_used];
   end

   // ------------------------------------------------------------------------
   // S1: input register
   // ------------------------------------------------------------------------
   logic [c_used-1:0] r_s1_data;
   logic              r_s1_vld;

   always_ff @(posedge wClk or posedge wRst) begin
      if (wRst) begin
         r_s1_data <= '0;
         r_s1_vld  <= 1'b0;
      end else begin
         r_s1_data <= wDecoIn[c_used-1:0];
         r_s1_vld  <= wSampleValid;
      end
   end

   // ------------------------------------------------------------------------
   // S2: match vector. m[i] = old level at i, new level on the WIN taps above.
   // ------------------------------------------------------------------------
   logic [c_scan-1:0] w_match;

   for (genvar i = 0; i < c_scan; i++) begin : g_match
      if (i + WIN <= NUM_FF - 1) begin : g_eval
         assign w_match[i] = (r_s1_data[i] == ~c_pol) &&
                             (r_s1_data[i+1 +: WIN] == {WIN{c_pol}});
      end else begin : g_skip
         assign w_match[i] = 1'b0;
      end
   end

   logic [c_scan-1:0] r_s2_match;
   logic              r_s2_vld;

   always_ff @(posedge wClk or posedge wRst) begin
      if (wRst) begin
         r_s2_match <= '0;
         r_s2_vld   <= 1'b0;
      end else begin
         r_s2_match <= w_match;
         r_s2_vld   <= r_s1_vld;
      end
   end

   // ------------------------------------------------------------------------
   // S3: highest-index match wins; a second set bit anywhere marks a bubble.
   // ------------------------------------------------------------------------
   logic [BITS_DECO-1:0] w_bin;
   logic                 w_any;
   logic                 w_multi;

   always_comb begin
      w_bin   = '0;
      w_any   = 1'b0;
      w_multi = 1'b0;
      for (int i = 0; i < c_scan; i++) begin
         if (r_s2_match[i]) begin
            if (w_any) begin
               w_multi = 1'b1;
            end
            w_any = 1'b1;
            w_bin = BITS_DECO'(i + 1);
         end
      end
   end

   // Result registers only load on a valid sample so they hold otherwise.
   always_ff @(posedge wClk or posedge wRst) begin
      if (wRst) begin
         wDecoOut    <= '0;
         wDecoValid  <= 1'b0;
         wDecoNoEdge <= 1'b0;
         wDecoMulti  <= 1'b0;
      end else begin
         wDecoValid <= r_s2_vld;
         if (r_s2_vld) begin
            wDecoOut    <= w_bin;
            wDecoNoEdge <= ~w_any;
            wDecoMulti  <= w_multi;
         end
      end
   end

`ifdef TDC_DECO_STATS_EN
   // ------------------------------------------------------------------------
   // Saturating event counters, fed from the registered result strobe.
   // ------------------------------------------------------------------------
   logic [15:0] r_stat_noedge;
   logic [15:0] r_stat_multi;

   always_ff @(posedge wClk or posedge wRst) begin
      if (wRst) begin
         r_stat_noedge <= '0;
         r_stat_multi  <= '0;
      end else if (wStatClr) begin
         r_stat_noedge <= '0;
         r_stat_multi  <= '0;
      end else begin
         if (wDecoValid && wDecoNoEdge && (r_stat_noedge != 16'hFFFF)) begin
            r_stat_noedge <= r_stat_noedge + 16'd1;
         end
         if (wDecoValid && wDecoMulti && (r_stat_multi != 16'hFFFF)) begin
            r_stat_multi <= r_stat_multi + 16'd1;
         end
      end
   end

   assign wStatNoEdge = r_stat_noedge;
   assign wStatMulti  = r_stat_multi;
`endif

endmodule
`default_nettype wire

// File: tb/tb_tdc_thermo_decoder.sv
`default_nettype none
// ============================================================================
// Module  : tb_tdc_thermo_decoder
// Brief   : Self-checking bench for tdc_thermo_decoder (NUM_FF=64, GUARD=20,
//           WIN=4, EDGE_POL=1, BITS_DECO=8). Directed vector table plus
//           hand-written back-to-back, reset and statistics sequences.
// Revision: 1.0 - initial release
// ============================================================================
module tb_tdc_thermo_decoder;

   localparam int NUM_FF = 64;
   localparam int BITS   = 8;

   logic              clk;
   logic              wRst;
   logic              wSampleValid;
   logic [NUM_FF-1:0] wDecoIn;
   logic [BITS-1:0]   wDecoOut;
   logic              wDecoValid;
   logic              wDecoNoEdge;
   logic              wDecoMulti;
`ifdef TDC_DECO_STATS_EN
   logic              wStatClr;
   logic [15:0]       wStatNoEdge;
   logic [15:0]       wStatMulti;
`endif

   int total = 0;
   int bad   = 0;

   tdc_thermo_decoder #(
      .NUM_FF   (NUM_FF),
      .BITS_DECO(BITS),
      .WIN      (4),
      .GUARD    (20),
      .EDGE_POL (1)
   ) dut (
      .wClk        (clk),
      .wRst        (wRst),
      .wSampleValid(wSampleValid),
      .wDecoIn     (wDecoIn),
      .wDecoOut    (wDecoOut),
      .wDecoValid  (wDecoValid),
      .wDecoNoEdge (wDecoNoEdge),
      .wDecoMulti  (wDecoMulti)
`ifdef TDC_DECO_STATS_EN
      ,
      .wStatClr    (wStatClr),
      .wStatNoEdge (wStatNoEdge),
      .wStatMulti  (wStatMulti)
`endif
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      string             name;
      logic [NUM_FF-1:0] d;
      int                out;
      int                noedge;
      int                multi;
   } vec_t;

   vec_t vecs[10];

   task automatic chk(input string nm, input int act, input int exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s actual=%0d required=%0d", nm, act, exp);
      end
   endtask

   // One-cycle valid sample; returns #1 after the capturing edge.
   task automatic apply(input logic [NUM_FF-1:0] d);
      wSampleValid = 1'b1;
      wDecoIn      = d;
      @(posedge clk);
      #1;
      wSampleValid = 1'b0;
   endtask

   // Count edges (starting at the capture edge) until wDecoValid, bounded.
   task automatic wait_valid(output int n);
      n = 1;
      while (!wDecoValid && n < 10) begin
         @(posedge clk);
         #1;
         n++;
      end
   endtask

   task automatic run_vec(input vec_t v);
      int n;
      apply(v.d);
      wait_valid(n);
      chk({v.name, "_latency"}, n, 3);
      chk({v.name, "_valid"}, int'(wDecoValid), 1);
      chk({v.name, "_out"}, int'(wDecoOut), v.out);
      chk({v.name, "_noedge"}, int'(wDecoNoEdge), v.noedge);
      chk({v.name, "_multi"}, int'(wDecoMulti), v.multi);
      @(posedge clk);
      #1;
      chk({v.name, "_strobe"}, int'(wDecoValid), 0);
      chk({v.name, "_hold"}, int'(wDecoOut), v.out);
   endtask

   logic [NUM_FF-1:0] ones;

   initial begin
      int  n;
      bit  seen;
      ones = '1;

      vecs[0] = '{"clean",   ones << 10,                       10, 0, 0};
      vecs[1] = '{"bubble",  (ones << 10) & ~(64'd1 << 30),    31, 0, 1};
      vecs[2] = '{"allone",  ones,                              0, 1, 0};
      vecs[3] = '{"allzero", '0,                                0, 1, 0};
      vecs[4] = '{"edge44",  ones << 45,                        0, 1, 0};
      vecs[5] = '{"edge43",  ones << 44,                       44, 0, 0};
      vecs[6] = '{"edge0",   ones << 1,                         1, 0, 0};
      vecs[7] = '{"shortrun",(ones << 10) & ~(64'd1 << 13),    14, 0, 0};
      vecs[8] = '{"winrun",  (ones << 10) & ~(64'd1 << 14),    15, 0, 1};
      vecs[9] = '{"falling", ~(ones << 10),                     0, 1, 0};

      wRst         = 1'b1;
      wSampleValid = 1'b0;
      wDecoIn      = '0;
`ifdef TDC_DECO_STATS_EN
      wStatClr     = 1'b0;
`endif
      #2;
      chk("rst_valid",  int'(wDecoValid),  0);
      chk("rst_out",    int'(wDecoOut),    0);
      chk("rst_noedge", int'(wDecoNoEdge), 0);
      chk("rst_multi",  int'(wDecoMulti),  0);
      repeat (2) @(posedge clk);
      @(negedge clk);
      wRst = 1'b0;
      @(posedge clk);
      #1;

      for (int k = 0; k < 10; k++) begin
         run_vec(vecs[k]);
      end

      // Back-to-back samples on consecutive cycles
      wSampleValid = 1'b1;
      wDecoIn = ones << 4;
      @(posedge clk); #1;
      wDecoIn = ones << 18;
      @(posedge clk); #1;
      wDecoIn = ones << 41;
      @(posedge clk); #1;
      wSampleValid = 1'b0;
      chk("b2b0_valid", int'(wDecoValid), 1);
      chk("b2b0_out",   int'(wDecoOut),   4);
      @(posedge clk); #1;
      chk("b2b1_valid", int'(wDecoValid), 1);
      chk("b2b1_out",   int'(wDecoOut),   18);
      @(posedge clk); #1;
      chk("b2b2_valid", int'(wDecoValid), 1);
      chk("b2b2_out",   int'(wDecoOut),   41);
      @(posedge clk); #1;
      chk("b2b_end",    int'(wDecoValid), 0);

      // Reset mid-stream drops in-flight samples
      wSampleValid = 1'b1;
      wDecoIn = ones << 10;
      @(posedge clk); #1;
      wDecoIn = ones << 18;
      @(posedge clk); #1;
      wSampleValid = 1'b0;
      #2 wRst = 1'b1;
      #1;
      chk("midrst_out_async", int'(wDecoOut), 0);
      chk("midrst_valid",     int'(wDecoValid), 0);
      @(posedge clk); #1;
      chk("midrst_out_held", int'(wDecoOut), 0);
      @(negedge clk);
      wRst = 1'b0;
      seen = 1'b0;
      for (int k = 0; k < 6; k++) begin
         @(posedge clk); #1;
         if (wDecoValid || wDecoOut != 0 || wDecoNoEdge || wDecoMulti) seen = 1'b1;
      end
      chk("postrst_quiet", int'(seen), 0);

      // Pipeline operates normally after reset
      apply(ones << 10);
      wait_valid(n);
      chk("postrst_latency", n, 3);
      chk("postrst_out", int'(wDecoOut), 10);

      // Bubble cycle between two samples keeps the gap
      apply(ones << 5);
      @(posedge clk); #1;
      apply(ones << 7);
      wait_valid(n);
      chk("gap_first_out", int'(wDecoOut), 5);
      @(posedge clk); #1;
      chk("gap_hole", int'(wDecoValid), 0);
      @(posedge clk); #1;
      chk("gap_second_valid", int'(wDecoValid), 1);
      chk("gap_second_out", int'(wDecoOut), 7);

`ifdef TDC_DECO_STATS_EN
      @(posedge clk); #1;
      wStatClr = 1'b1;
      @(posedge clk); #1;
      wStatClr = 1'b0;
      chk("stat_clr0_noedge", int'(wStatNoEdge), 0);
      chk("stat_clr0_multi",  int'(wStatMulti),  0);
      for (int k = 0; k < 3; k++) begin
         apply('0);
         wait_valid(n);
      end
      for (int k = 0; k < 2; k++) begin
         apply(vecs[1].d);
         wait_valid(n);
      end
      repeat (2) @(posedge clk);
      #1;
      chk("stat_noedge", int'(wStatNoEdge), 3);
      chk("stat_multi",  int'(wStatMulti),  2);
      wStatClr = 1'b1;
      @(posedge clk); #1;
      wStatClr = 1'b0;
      chk("stat_clr_noedge", int'(wStatNoEdge), 0);
      chk("stat_clr_multi",  int'(wStatMulti),  0);
      force dut.r_stat_noedge = 16'hFFFF;
      #1;
      release dut.r_stat_noedge;
      apply('0);
      wait_valid(n);
      repeat (2) @(posedge clk);
      #1;
      chk("stat_saturate", int'(wStatNoEdge), 32'hFFFF);
`endif

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
`default_nettype wire
